// File: rtl/mbscore_int_requester.sv
// Device-side interrupt requester: latches IRQ sources, arbitrates by fixed
// priority, presents a vector until ack, tracks the handler until EOI.
module mbscore_int_requester #(
  parameter int NUM_SRC = 7,
  parameter int VEC_WIDTH = 3,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = 7'b1111111
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   irq_in,
  input  logic [NUM_SRC-1:0]   irq_mask,
  input  logic                 int_ack,
  input  logic                 int_eoi,
  output logic [VEC_WIDTH-1:0] int_vec,
  output logic                 int_active,
  output logic [NUM_SRC-1:0]   pending
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t state, state_n;

  logic [NUM_SRC-1:0]   irq_d;
  logic [NUM_SRC-1:0]   pend_e;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   clr;
  logic [NUM_SRC-1:0]   elig;
  logic [NUM_SRC-1:0]   win_oh;
  logic [NUM_SRC-1:0]   sel_oh, sel_n;
  logic [VEC_WIDTH-1:0] win_code;
  logic [VEC_WIDTH-1:0] vec_n;
  logic                 act_n;
  logic                 withdraw;

  // Edge sources are latched; level sources follow the line directly.
  assign rise    = irq_in & ~irq_d & EDGE_MASK;
  assign pending = (pend_e & EDGE_MASK) | (irq_in & ~EDGE_MASK);
  assign elig    = pending & ~irq_mask;
  assign withdraw = |(sel_oh & (irq_mask | ~pending));

  always_comb begin
    win_oh   = '0;
    win_code = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_code  = VEC_WIDTH'(i + 1);
      end
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = int_vec;
    act_n   = int_active;
    sel_n   = sel_oh;
    clr     = '0;
    unique case (state)
      IDLE: begin
        vec_n = '0;
        if (|elig) begin
          state_n = REQ;
          vec_n   = win_code;
          sel_n   = win_oh;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_n = SERVICE;
          vec_n   = '0;
          act_n   = 1'b1;
          clr     = sel_oh & EDGE_MASK;
        end else if (withdraw) begin
          state_n = IDLE;
          vec_n   = '0;
        end
      end
      SERVICE: begin
        vec_n = '0;
        if (int_eoi) begin
          state_n = IDLE;
          act_n   = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        vec_n   = '0;
        act_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      int_vec    <= '0;
      int_active <= 1'b0;
      sel_oh     <= '0;
      irq_d      <= '0;
      pend_e     <= '0;
    end else begin
      state      <= state_n;
      int_vec    <= vec_n;
      int_active <= act_n;
      sel_oh     <= sel_n;
      irq_d      <= irq_in;
      pend_e     <= (pend_e & ~clr) | rise;
    end
  end

endmodule

// File: tb/tb_mbscore_int_requester.sv
// Directed testbench for mbscore_int_requester.
// Inputs change 1ns after posedge; outputs checked before the next edge.
module tb_mbscore_int_requester;

  logic       clk;
  logic       rst_n;
  logic [6:0] irq_in;
  logic [6:0] irq_mask;
  logic       int_ack;
  logic       int_eoi;
  logic [2:0] int_vec;
  logic       int_active;
  logic [6:0] pending;

  int tests;
  int fails;

  mbscore_int_requester dut (
    .clk(clk),
    .rst_n(rst_n),
    .irq_in(irq_in),
    .irq_mask(irq_mask),
    .int_ack(int_ack),
    .int_eoi(int_eoi),
    .int_vec(int_vec),
    .int_active(int_active),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_irq(input int b);
    irq_in[b] = 1'b1;
    tick();
    irq_in[b] = 1'b0;
  endtask

  task automatic serve();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    int_eoi = 1'b1;
    tick();
    int_eoi = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    irq_in = '0;
    irq_mask = '0;
    int_ack = 1'b0;
    int_eoi = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests++;
      if (int_vec !== 3'd0 || int_active !== 1'b0 || pending !== 7'd0) begin
        fails++;
        $display("FAIL reset c%0d: vec=%0d act=%0b pend=%b, want 0/0/0",
                 c, int_vec, int_active, pending);
      end
    end
  endtask

  task automatic test_single();
    pulse_irq(1);
    tests++;
    if (pending !== 7'b0000010 || int_vec !== 3'd0) begin
      fails++;
      $display("FAIL single_pend: pend=%b vec=%0d, want 0000010/0",
               pending, int_vec);
    end
    tick();
    tests++;
    if (int_vec !== 3'd2) begin
      fails++;
      $display("FAIL single_vec: vec=%0d, want 2", int_vec);
    end
    int_eoi = 1'b1;
    tick();
    int_eoi = 1'b0;
    tests++;
    if (int_vec !== 3'd2 || int_active !== 1'b0) begin
      fails++;
      $display("FAIL eoi_in_req: vec=%0d act=%0b, want 2/0",
               int_vec, int_active);
    end
    int_ack = 1'b1;
    tick();
    tests++;
    if (int_vec !== 3'd0 || int_active !== 1'b1 || pending[1] !== 1'b0) begin
      fails++;
      $display("FAIL single_ack: vec=%0d act=%0b pend=%b, want 0/1/p1=0",
               int_vec, int_active, pending);
    end
    tick();
    int_ack = 1'b0;
    tests++;
    if (int_active !== 1'b1 || int_vec !== 3'd0) begin
      fails++;
      $display("FAIL ack_held: vec=%0d act=%0b, want 0/1",
               int_vec, int_active);
    end
    int_eoi = 1'b1;
    tick();
    int_eoi = 1'b0;
    tests++;
    if (int_active !== 1'b0 || int_vec !== 3'd0) begin
      fails++;
      $display("FAIL single_eoi: vec=%0d act=%0b, want 0/0",
               int_vec, int_active);
    end
    tick();
    tests++;
    if (int_vec !== 3'd0) begin
      fails++;
      $display("FAIL post_eoi: vec=%0d, want 0", int_vec);
    end
  endtask

  task automatic test_priority();
    irq_in[3] = 1'b1;
    irq_in[0] = 1'b1;
    tick();
    irq_in = '0;
    tests++;
    if (pending !== 7'b0001001) begin
      fails++;
      $display("FAIL prio_pend: pend=%b, want 0001001", pending);
    end
    tick();
    tests++;
    if (int_vec !== 3'd1) begin
      fails++;
      $display("FAIL prio_vec: vec=%0d, want 1", int_vec);
    end
    serve();
    tests++;
    if (int_vec !== 3'd0 || int_active !== 1'b0 || pending !== 7'b0001000) begin
      fails++;
      $display("FAIL prio_gap: vec=%0d act=%0b pend=%b, want 0/0/0001000",
               int_vec, int_active, pending);
    end
    tick();
    tests++;
    if (int_vec !== 3'd4) begin
      fails++;
      $display("FAIL prio_next: vec=%0d, want 4", int_vec);
    end
    serve();
  endtask

  task automatic test_back_to_back();
    tick();
    pulse_irq(4);
    tick();
    tests++;
    if (int_vec !== 3'd5) begin
      fails++;
      $display("FAIL b2b_vec5: vec=%0d, want 5", int_vec);
    end
    pulse_irq(0);
    tick();
    tests++;
    if (int_vec !== 3'd5 || pending !== 7'b0010001) begin
      fails++;
      $display("FAIL b2b_hold: vec=%0d pend=%b, want 5/0010001",
               int_vec, pending);
    end
    serve();
    tests++;
    if (pending !== 7'b0000001 || int_vec !== 3'd0) begin
      fails++;
      $display("FAIL b2b_clr: vec=%0d pend=%b, want 0/0000001",
               int_vec, pending);
    end
    tick();
    tests++;
    if (int_vec !== 3'd1) begin
      fails++;
      $display("FAIL b2b_next: vec=%0d, want 1", int_vec);
    end
    serve();
  endtask

  task automatic test_mask();
    tick();
    irq_mask[2] = 1'b1;
    pulse_irq(2);
    tick();
    tests++;
    if (int_vec !== 3'd0 || pending !== 7'b0000100) begin
      fails++;
      $display("FAIL mask_hold: vec=%0d pend=%b, want 0/0000100",
               int_vec, pending);
    end
    irq_mask[2] = 1'b0;
    tick();
    tests++;
    if (int_vec !== 3'd3) begin
      fails++;
      $display("FAIL mask_clear: vec=%0d, want 3", int_vec);
    end
    serve();
  endtask

  task automatic test_withdraw();
    tick();
    pulse_irq(6);
    tick();
    tests++;
    if (int_vec !== 3'd7) begin
      fails++;
      $display("FAIL wd_vec: vec=%0d, want 7", int_vec);
    end
    irq_mask[6] = 1'b1;
    tick();
    tests++;
    if (int_vec !== 3'd0 || pending[6] !== 1'b1) begin
      fails++;
      $display("FAIL wd_drop: vec=%0d pend=%b, want 0/p6=1",
               int_vec, pending);
    end
    irq_mask[6] = 1'b0;
    tick();
    tests++;
    if (int_vec !== 3'd7) begin
      fails++;
      $display("FAIL wd_rearb: vec=%0d, want 7", int_vec);
    end
    irq_mask[6] = 1'b1;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    irq_mask[6] = 1'b0;
    tests++;
    if (int_active !== 1'b1 || int_vec !== 3'd0 || pending[6] !== 1'b0) begin
      fails++;
      $display("FAIL wd_ackwins: act=%0b vec=%0d pend=%b, want 1/0/p6=0",
               int_active, int_vec, pending);
    end
    int_eoi = 1'b1;
    tick();
    int_eoi = 1'b0;
  endtask

  task automatic test_async_reset();
    tick();
    pulse_irq(5);
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    pulse_irq(5);
    tests++;
    if (int_active !== 1'b1 || pending[5] !== 1'b1) begin
      fails++;
      $display("FAIL rst_setup: act=%0b pend=%b, want 1/p5=1",
               int_active, pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (int_vec !== 3'd0 || int_active !== 1'b0 || pending !== 7'd0) begin
      fails++;
      $display("FAIL async_rst: vec=%0d act=%0b pend=%b, want 0/0/0",
               int_vec, int_active, pending);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tests++;
    if (int_vec !== 3'd0 || int_active !== 1'b0) begin
      fails++;
      $display("FAIL post_rst: vec=%0d act=%0b, want 0/0",
               int_vec, int_active);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_priority();
    test_back_to_back();
    test_mask();
    test_withdraw();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
